register_wpos_clkneg_universal: RTL and testbench

REGISTER_WPOS_CLKNEG_UNIVERSAL -- requirements
Module: register_wpos_clkneg_universal

---
 rtl/register_wpos_clkneg_universal_pkg.sv | 17 +
 rtl/register_wpos_clkneg_universal_next_value.sv | 44 ++++
 rtl/register_wpos_clkneg_universal.sv | 60 ++++++
 tb/tb_register_wpos_clkneg_universal.sv | 131 +++++++++++++
 4 files changed

// File: rtl/register_wpos_clkneg_universal_pkg.sv
// Shared mode codes for the falling-edge universal register.
// Build option: REGISTER_UNIVERSAL_COUNT_EN enables the increment/decrement modes.
`ifndef REGISTER_WPOS_CLKNEG_UNIVERSAL_PKG_SV
`define REGISTER_WPOS_CLKNEG_UNIVERSAL_PKG_SV
package register_wpos_clkneg_universal_pkg;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;
endpackage
`endif

// File: rtl/register_wpos_clkneg_universal_next_value.sv
// Combinational next-value selector for the universal register.
// Build option: REGISTER_UNIVERSAL_COUNT_EN adds the counter arithmetic.
module universal_next_value
    import register_wpos_clkneg_universal_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  cur_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  load_i,
    input  logic              ser_l_i,
    input  logic              ser_r_i,
    output logic [WIDTH-1:0]  nxt_o,
    output logic              wrap_o
);
`ifdef REGISTER_UNIVERSAL_COUNT_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    always_comb begin
        nxt_o  = cur_i;
        wrap_o = 1'b0;
        case (mode_i)
            MODE_HOLD: nxt_o = cur_i;
            MODE_LOAD: nxt_o = load_i;
            MODE_SHL:  nxt_o = {cur_i[WIDTH-2:0], ser_l_i};
            MODE_SHR:  nxt_o = {ser_r_i, cur_i[WIDTH-1:1]};
            MODE_ROL:  nxt_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
            MODE_ROR:  nxt_o = {cur_i[0], cur_i[WIDTH-1:1]};
`ifdef REGISTER_UNIVERSAL_COUNT_EN
            MODE_INC: begin
                nxt_o  = cur_i + ONE;
                wrap_o = &cur_i;
            end
            MODE_DEC: begin
                nxt_o  = cur_i - ONE;
                wrap_o = ~|cur_i;
            end
`endif
            // Without the counter option, the count codes simply hold.
            default: nxt_o = cur_i;
        endcase
    end
endmodule

// File: rtl/register_wpos_clkneg_universal.sv
// Falling-edge universal register: load, shift, rotate and optional count.
// Build option: REGISTER_UNIVERSAL_COUNT_EN enables modes 6/7 and the Carry pulse.
module register_wpos_clkneg_universal
    import register_wpos_clkneg_universal_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Rstbar,
    input  logic              Enbar,
    input  logic [MODE_W-1:0] Mode,
    input  logic [WIDTH-1:0]  in,
    input  logic              SerInL,
    input  logic              SerInR,
    output logic [WIDTH-1:0]  out,
    output logic              SerOutL,
    output logic              SerOutR,
    output logic              Zero,
    output logic              Carry
);
    logic [WIDTH-1:0] out_q, out_d, nxt_val;
    logic             carry_q, carry_d, wrap;

    universal_next_value #(.WIDTH(WIDTH)) u_next (
        .cur_i   (out_q),
        .mode_i  (Mode),
        .load_i  (in),
        .ser_l_i (SerInL),
        .ser_r_i (SerInR),
        .nxt_o   (nxt_val),
        .wrap_o  (wrap)
    );

    // Carry is only ever a one-edge pulse, so a held edge clears it too.
    always_comb begin
        out_d   = out_q;
        carry_d = 1'b0;
        if (!Enbar) begin
            out_d   = nxt_val;
            carry_d = wrap;
        end
    end

    always_ff @(negedge Clk or negedge Rstbar) begin
        if (!Rstbar) begin
            out_q   <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out     = out_q;
    assign SerOutL = out_q[WIDTH-1];
    assign SerOutR = out_q[0];
    assign Zero    = (out_q == '0);
    assign Carry   = carry_q;
endmodule

// File: tb/tb_register_wpos_clkneg_universal.sv
// Directed bench for the falling-edge universal register at WIDTH 8 and 4.
module tb_register_wpos_clkneg_universal;
    logic       Clk = 1'b1;
    logic       Rstbar = 1'b1;
    logic       Enbar = 1'b1;
    logic [2:0] Mode = 3'd0;
    logic [7:0] in8 = 8'h00;
    logic [3:0] in4 = 4'h0;
    logic       SerInL = 1'b0;
    logic       SerInR = 1'b0;
    logic [7:0] out8;
    logic [3:0] out4;
    logic       sol8, sor8, zero8, carry8;
    logic       sol4, sor4, zero4, carry4;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    register_wpos_clkneg_universal #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .Clk(Clk), .Rstbar(Rstbar), .Enbar(Enbar), .Mode(Mode), .in(in8),
        .SerInL(SerInL), .SerInR(SerInR), .out(out8), .SerOutL(sol8),
        .SerOutR(sor8), .Zero(zero8), .Carry(carry8)
    );

    register_wpos_clkneg_universal #(.WIDTH(4), .RESET_VALUE(4'h5)) dut4 (
        .Clk(Clk), .Rstbar(Rstbar), .Enbar(Enbar), .Mode(Mode), .in(in4),
        .SerInL(SerInL), .SerInR(SerInR), .out(out4), .SerOutL(sol4),
        .SerOutR(sor4), .Zero(zero4), .Carry(carry4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        // Reset between edges: takes effect with no clock edge.
        #2 Rstbar = 1'b0;
        #1;
        check("rst_out8", out8, 8'hA5);
        check("rst_carry8", carry8, 1'b0);
        check("rst_out4", out4, 4'h5);
        check("rst_serout8", {sol8, sor8, zero8}, 3'b110);
        #5 Rstbar = 1'b1;
        #1;
        check("rel_no_edge", out8, 8'hA5);

        Enbar = 1'b0; Mode = 3'd1; in8 = 8'h3C; in4 = 4'hC;
        tick();
        check("load8", out8, 8'h3C);
        check("load4", out4, 4'hC);
        Enbar = 1'b1; in8 = 8'hFF; Mode = 3'd1;
        tick();
        check("hold_en", out8, 8'h3C);

        Enbar = 1'b0; Mode = 3'd1; in8 = 8'h81;
        tick();
        check("load81", {sol8, sor8, zero8}, 3'b110);
        Mode = 3'd4; SerInL = 1'b0; tick();
        check("rol", out8, 8'h03);
        Mode = 3'd5; SerInR = 1'b0; tick();
        check("ror", out8, 8'h81);
        Mode = 3'd3; SerInR = 1'b0; tick();
        check("shr", out8, 8'h40);
        Mode = 3'd2; SerInL = 1'b1; tick();
        check("shl", out8, 8'h81);
        Mode = 3'd0; tick();
        check("mode_hold", out8, 8'h81);

        Mode = 3'd1; in8 = 8'h00; tick();
        check("zero_flag", zero8, 1'b1);

        // Counter wrap at both widths.
        Mode = 3'd1; in8 = 8'hFF; in4 = 4'hF; tick();
        Mode = 3'd6; tick();
`ifdef REGISTER_UNIVERSAL_COUNT_EN
        check("inc_wrap8", {carry8, out8}, 9'h100);
        check("inc_wrap4", {carry4, out4}, 5'h10);
`else
        check("inc_off8", {carry8, out8}, 9'h0FF);
        check("inc_off4", {carry4, out4}, 5'h0F);
`endif
        Enbar = 1'b1; tick();
        check("carry_clr8", carry8, 1'b0);
        check("carry_clr4", carry4, 1'b0);

        Enbar = 1'b0; Mode = 3'd1; in8 = 8'h00; in4 = 4'h0; tick();
        Mode = 3'd7; tick();
`ifdef REGISTER_UNIVERSAL_COUNT_EN
        check("dec_wrap8", {carry8, out8}, 9'h1FF);
        check("dec_wrap4", {carry4, out4}, 5'h1F);
`else
        check("dec_off8", {carry8, out8}, 9'h000);
        check("dec_off4", {carry4, out4}, 5'h00);
`endif

        // Reset pulsed 2 ns before an edge while counting.
        Mode = 3'd1; in8 = 8'h10; in4 = 4'h2; tick();
        Mode = 3'd6;
        #7 Rstbar = 1'b0;
        #1;
        check("midrst_imm", out8, 8'hA5);
        tick();
        check("midrst_edge8", {carry8, out8}, 9'h0A5);
        check("midrst_edge4", out4, 4'h5);
        Rstbar = 1'b1;
        tick();
`ifdef REGISTER_UNIVERSAL_COUNT_EN
        check("resume8", out8, 8'hA6);
        check("resume4", out4, 4'h6);
`else
        check("resume8", out8, 8'hA5);
        check("resume4", out4, 4'h5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
